// File: rtl/mul_ctrl_pkg.sv
// Shared definitions for the multiply sequencer: op encodings, multiplier
// signedness codes, sequencer states, fuse-cache entry layout and the
// op-to-signedness / result-selection helpers.
package mul_ctrl_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned BUSY_W = 32;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  // {src1 signed, src2 signed}
  localparam logic [1:0] SGN_SS = 2'b11;
  localparam logic [1:0] SGN_SU = 2'b10;
  localparam logic [1:0] SGN_UU = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [1:0]        sgn;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } fuse_entry_t;

  // Signedness the multiplier needs for a given op (MULW uses MUL's code).
  function automatic logic [1:0] op_sgn(input logic [1:0] op);
    logic [1:0] s;
    case (op)
      OP_MULHSU: s = SGN_SU;
      OP_MULHU:  s = SGN_UU;
      default:   s = SGN_SS;
    endcase
    return s;
  endfunction

  // Pick the architectural result out of the 128-bit product.
  function automatic logic [DATA_W-1:0] sel_result(input logic [1:0]        op,
                                                   input logic              w,
                                                   input logic [DATA_W-1:0] hi,
                                                   input logic [DATA_W-1:0] lo);
    logic [DATA_W-1:0] r;
    if (w)                r = {{32{lo[31]}}, lo[31:0]};
    else if (op == OP_MUL) r = lo;
    else                  r = hi;
    return r;
  endfunction

endpackage

// File: rtl/mul_fuse_cache.sv
// One-entry result cache for back-to-back multiplies on identical operands
// (e.g. MULH followed by MUL). Only built when YSYX_22050133_MUL_FUSE_EN is
// defined.
// Ports: clk/rst (async active-high), flush and inv clear the entry;
// wr_* writes a completed non-W product; lk_* is the incoming request;
// hit_c / hit_data_c are the combinational lookup result.
module mul_fuse_cache
  import mul_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        inv,
  input  logic        wr_en,
  input  logic [63:0] wr_src1,
  input  logic [63:0] wr_src2,
  input  logic [1:0]  wr_sgn,
  input  logic [63:0] wr_hi,
  input  logic [63:0] wr_lo,
  input  logic [63:0] lk_src1,
  input  logic [63:0] lk_src2,
  input  logic [1:0]  lk_op,
  input  logic        lk_w,
  output logic        hit_c,
  output logic [63:0] hit_data_c
);

  logic        valid_q, valid_d;
  fuse_entry_t entry_q, entry_d;

  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    if (flush || inv) valid_d = 1'b0;
    if (wr_en) begin
      valid_d = 1'b1;
      entry_d = '{src1: wr_src1, src2: wr_src2, sgn: wr_sgn, hi: wr_hi, lo: wr_lo};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  // The low half does not depend on signedness, so MUL hits any cached op.
  assign hit_c = valid_q && !lk_w &&
                 (lk_src1 == entry_q.src1) && (lk_src2 == entry_q.src2) &&
                 ((lk_op == OP_MUL) || (op_sgn(lk_op) == entry_q.sgn));
  assign hit_data_c = (lk_op == OP_MUL) ? entry_q.lo : entry_q.hi;

endmodule

// File: rtl/mul_ctrl.sv
// Sequencer between execute and the shared radix-4 Booth multiplier.
// Accepts MUL/MULH/MULHSU/MULHU/MULW over req_*, issues to the multiplier
// over mul_*, waits for its ready to fall and rise again, then returns the
// selected result over resp_*. flush cancels everything and is forwarded
// as mul_flush. busy_cycles counts ISSUE+WAIT cycles (saturating).
// Optional: YSYX_22050133_MUL_FUSE_EN adds a one-entry result cache so a
// repeated operand pair is answered without using the multiplier.
module mul_ctrl
  import mul_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic            req_w,
  input  logic [XLEN-1:0] req_src1,
  input  logic [XLEN-1:0] req_src2,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            mul_valid,
  output logic            mul_mulw,
  output logic [1:0]      mul_signed,
  output logic [XLEN-1:0] mul_a,
  output logic [XLEN-1:0] mul_b,
  output logic            mul_flush,
  input  logic            mul_ready,
  input  logic [XLEN-1:0] mul_hi,
  input  logic [XLEN-1:0] mul_lo,
  output logic [31:0]     busy_cycles
);

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic [1:0]        sgn_q, sgn_d;
  logic              w_q, w_d;
  logic              seen_low_q, seen_low_d;
  logic [XLEN-1:0]   resp_data_q, resp_data_d;
  logic [BUSY_W-1:0] busy_q, busy_d;
  logic              hit_c;
  logic [XLEN-1:0]   hit_data_c;

`ifdef YSYX_22050133_MUL_FUSE_EN
  logic cache_wr;
  logic issue_entry;

  assign cache_wr    = (state_q == ST_WAIT) && seen_low_q && mul_ready && !w_q && !flush;
  assign issue_entry = (state_q == ST_IDLE) && req_valid && !flush && !hit_c;

  mul_fuse_cache u_fuse_cache (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .inv        (issue_entry),
    .wr_en      (cache_wr),
    .wr_src1    (a_q),
    .wr_src2    (b_q),
    .wr_sgn     (sgn_q),
    .wr_hi      (mul_hi),
    .wr_lo      (mul_lo),
    .lk_src1    (req_src1),
    .lk_src2    (req_src2),
    .lk_op      (req_op),
    .lk_w       (req_w),
    .hit_c      (hit_c),
    .hit_data_c (hit_data_c)
  );
`else
  assign hit_c      = 1'b0;
  assign hit_data_c = '0;
`endif

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    sgn_d       = sgn_q;
    w_d         = w_q;
    seen_low_d  = seen_low_q;
    resp_data_d = resp_data_q;
    busy_d      = busy_q;

    if (((state_q == ST_ISSUE) || (state_q == ST_WAIT)) && (busy_q != '1))
      busy_d = busy_q + BUSY_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (req_valid && !flush) begin
          op_d  = req_op;
          a_d   = req_src1;
          b_d   = req_src2;
          sgn_d = op_sgn(req_op);
          w_d   = req_w;
          if (hit_c) begin
            resp_data_d = hit_data_c;
            state_d     = ST_RESP;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (mul_ready) begin
          seen_low_d = 1'b0;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Completion is a rising mul_ready after it has been seen low.
        if (!mul_ready) seen_low_d = 1'b1;
        if (seen_low_q && mul_ready) begin
          resp_data_d = sel_result(op_q, w_q, mul_hi, mul_lo);
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_MUL;
      a_q         <= '0;
      b_q         <= '0;
      sgn_q       <= 2'b00;
      w_q         <= 1'b0;
      seen_low_q  <= 1'b0;
      resp_data_q <= '0;
      busy_q      <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sgn_q       <= sgn_d;
      w_q         <= w_d;
      seen_low_q  <= seen_low_d;
      resp_data_q <= resp_data_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready   = !rst && !flush && (state_q == ST_IDLE);
  assign mul_valid   = (state_q == ST_ISSUE);
  assign resp_valid  = (state_q == ST_RESP);
  assign resp_data   = resp_data_q;
  assign mul_a       = a_q;
  assign mul_b       = b_q;
  assign mul_signed  = sgn_q;
  assign mul_mulw    = w_q;
  assign mul_flush   = flush;
  assign busy_cycles = busy_q;

endmodule
